sevenseg_axil_slave: RTL and testbench
======================================

SEVENSEG_AXIL_SLAVE -- requirements
Module: sevenseg_axil_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, byte-address width covering 4 registers.
REQ-003 SHALL have port ACLK  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port ARESET  input  1  reset, asynchronous assert, active-high.
REQ-005 SHALL have AXI4-Lite write ports: S_AXI_AWADDR in 4, S_AXI_AWPROT in 3 (ignored), S_AXI_AWVALID in 1, S_AXI_AWREADY out 1, S_AXI_WDATA in 32, S_AXI_WSTRB in 4, S_AXI_WVALID in 1, S_AXI_WREADY out 1, S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1.
REQ-006 SHALL have AXI4-Lite read ports: S_AXI_ARADDR in 4, S_AXI_ARPROT in 3 (ignored), S_AXI_ARVALID in 1, S_AXI_ARREADY out 1, S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1.
REQ-007 SHALL have display ports: SEG out 7 (segments a..g = bits 0..6, active-low), DP out 1 (active-low), AN out 8 (digit enables, active-low).

Function
REQ-008 SHALL decode address bits [3:2]: 0=CTRL, 1=VALUE, 2=DPMASK, 3=DIV; bits [1:0] ignored.
REQ-009 SHALL store all 32 bits of every register and return them unmodified on read (full read/write, no reserved masking).
REQ-010 SHALL assert AWREADY and WREADY together for exactly one cycle when AWVALID=1, WVALID=1, and BVALID=0; register update occurs on that same edge.
REQ-011 SHALL update only bytes whose WSTRB bit is 1.
REQ-012 SHALL assert BVALID the cycle after the AW/W handshake with BRESP=00, and hold it until BREADY=1; no new write accepted while BVALID=1.
REQ-013 SHALL assert ARREADY for one cycle when ARVALID=1 and RVALID=0; RDATA captured at that edge, RVALID=1 next cycle with RRESP=00, held with stable RDATA until RREADY=1.
REQ-014 Simultaneous read and write acceptance to the same register SHALL return the pre-write value.
REQ-015 Read and write channels SHALL operate independently; one does not stall the other.
REQ-016 Scan counter SHALL count ACLK cycles and advance digit index when count equals DIV[15:0], then reset to 0; period = DIV[15:0]+1 cycles (DIV=0 advances every cycle).
REQ-017 Digit index SHALL run 0..7 and wrap 7->0.
REQ-018 A write to DIV SHALL reset scan counter to 0 without changing digit index.
REQ-019 When CTRL[0]=1: AN = one-hot-low at digit index i; SEG = hex 0-F segment pattern of VALUE[4i+3:4i]; DP = ~DPMASK[i].
REQ-020 When CTRL[0]=0: AN=8'hFF, SEG=7'h7F, DP=1; scan counter keeps running.
REQ-021 Hex patterns (gfedcba, active-low) SHALL be: 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10,A=08,b=03,C=46,d=21,E=06,F=0E.
REQ-022 Display outputs SHALL be registered (one cycle after index/register change).

Reset
REQ-023 ARESET=1 SHALL immediately clear all registers, scan counter, digit index, AWREADY, WREADY, BVALID, ARREADY, RVALID, RDATA, and set AN=8'hFF, SEG=7'h7F, DP=1.
REQ-024 Reset mid-transaction SHALL abandon it; no B or R response is issued after reset release.
REQ-025 First handshake SHALL be accepted no earlier than the first rising edge after ARESET deasserts.

Verification
REQ-026 Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, read back -> RDATA 0x1,0x2,0x3,0x4, all RESP=00.
REQ-027 VALUE=0xFFFFFFFF then write 0x00000012 with WSTRB=4'b0001 -> readback 0xFFFFFF12.
REQ-028 Write with BREADY held 0 for 5 cycles, second AW/W presented -> BVALID stays 1, AWREADY stays 0 until BREADY=1, then second write completes.
REQ-029 CTRL=1, VALUE=0x76543210, DPMASK=0x01, DIV=3 -> digit advances every 4 cycles; digit 0: AN=FE, SEG=40, DP=0; digit 7: AN=7F, SEG=78, DP=1; wrap to digit 0.
REQ-030 CTRL=0 -> AN=FF, SEG=7F, DP=1 regardless of VALUE.
REQ-031 Assert ARESET while BVALID=1 and RVALID=1 -> both drop immediately, registers read 0 after release.

Source files
------------

// File: rtl/sevenseg_axil_slave.sv
// sevenseg_axil_slave: AXI4-Lite register slave that drives an 8-digit multiplexed 7-segment display.
// Latency: write response and read data 1 cycle after the handshake edge; display outputs 1 cycle after an index or register change.
// Backpressure: one outstanding write and one outstanding read. AWREADY/WREADY stay low while BVALID is high; ARREADY stays low while RVALID is high.
//
// Ports:
//   ACLK, ARESET          clock (rising edge) and asynchronous active-high reset
//   S_AXI_AW*/W*/B*       AXI4-Lite write address, write data and write response channels
//   S_AXI_AR*/R*          AXI4-Lite read address and read data channels
//   SEG[6:0]              segments a..g on bits 0..6, active-low
//   DP                    decimal point, active-low
//   AN[7:0]               digit enables, active-low
//
// Register map (byte address bits [3:2]):
//   0 CTRL    bit 0 enables the display
//   1 VALUE   eight hex nibbles; digit i shows VALUE[4i+3:4i]
//   2 DPMASK  bit i lights the decimal point of digit i
//   3 DIV     bits [15:0] give the scan period minus one, in ACLK cycles
// All 32 bits of every register are stored and read back.

module sevenseg_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  // write address channel
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  // write data channel
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  // write response channel
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  // read address channel
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  // read data channel
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  // display
  output logic [6:0]                        SEG,
  output logic                              DP,
  output logic [7:0]                        AN
);

  localparam int NBYTES = C_S_AXI_DATA_WIDTH / 8;

  // register file
  logic [C_S_AXI_DATA_WIDTH-1:0] r_regs [4];

  // AXI channel state
  logic                          r_awready;
  logic                          r_bvalid;
  logic                          r_arready;
  logic                          r_rvalid;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;

  // scan state
  logic [15:0]                   r_scan_cnt;
  logic [2:0]                    r_digit;

  // registered display outputs
  logic [6:0]                    r_seg;
  logic                          r_dp;
  logic [7:0]                    r_an;

  logic                          w_wr_hs;
  logic                          w_rd_hs;
  logic [1:0]                    w_awidx;
  logic [1:0]                    w_aridx;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_ctrl;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_value;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_dpmask;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_div;
  logic [3:0]                    w_nibble;
  logic [6:0]                    w_seg_pat;
  logic                          w_div_wr;
  logic                          w_unused;

  assign w_awidx  = S_AXI_AWADDR[3:2];
  assign w_aridx  = S_AXI_ARADDR[3:2];
  assign w_ctrl   = r_regs[0];
  assign w_value  = r_regs[1];
  assign w_dpmask = r_regs[2];
  assign w_div    = r_regs[3];

  // Ready is registered, so a handshake completes on the edge where the
  // registered ready is already high and both valids are still present.
  assign w_wr_hs  = r_awready & S_AXI_AWVALID & S_AXI_WVALID;
  assign w_rd_hs  = r_arready & S_AXI_ARVALID;
  assign w_div_wr = w_wr_hs & (w_awidx == 2'd3);

  // Protection bits, byte-lane address bits and unused register bits are don't-care.
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                      w_div[31:16], w_ctrl[31:1]};

  // ---------------------------------------------------------------------------
  // Write path: AW and W are accepted together, one pulse per transaction.
  // The "& ~r_awready" term makes ready a single-cycle pulse; the response
  // then blocks further acceptance until BREADY drains it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
    end else begin
      r_awready <= S_AXI_AWVALID & S_AXI_WVALID & ~r_bvalid & ~r_awready;
      if (w_wr_hs) begin
        r_bvalid <= 1'b1;
      end else if (r_bvalid && S_AXI_BREADY) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int r = 0; r < 4; r++) begin
        r_regs[r] <= '0;
      end
    end else if (w_wr_hs) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (S_AXI_WSTRB[b]) begin
          r_regs[w_awidx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
        end
      end
    end
  end

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_awready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = 2'b00;

  // ---------------------------------------------------------------------------
  // Read path: data is sampled from the register file on the handshake edge,
  // so a write landing on the same edge is not visible (old value returned).
  // ---------------------------------------------------------------------------
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_arready <= S_AXI_ARVALID & ~r_rvalid & ~r_arready;
      if (w_rd_hs) begin
        r_rdata  <= r_regs[w_aridx];
        r_rvalid <= 1'b1;
      end else if (r_rvalid && S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = 2'b00;

  // ---------------------------------------------------------------------------
  // Scan counter: period is DIV[15:0]+1 cycles. A DIV write restarts the
  // period but leaves the current digit in place.
  // ---------------------------------------------------------------------------
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_scan_cnt <= '0;
      r_digit    <= '0;
    end else if (w_div_wr) begin
      r_scan_cnt <= '0;
    end else if (r_scan_cnt == w_div[15:0]) begin
      r_scan_cnt <= '0;
      r_digit    <= r_digit + 3'd1;
    end else begin
      r_scan_cnt <= r_scan_cnt + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Hex to segment decode (gfedcba, active-low)
  // ---------------------------------------------------------------------------
  assign w_nibble = w_value[{r_digit, 2'b00} +: 4];

  always_comb begin
    w_seg_pat = 7'h7F;
    case (w_nibble)
      4'h0: w_seg_pat = 7'h40;
      4'h1: w_seg_pat = 7'h79;
      4'h2: w_seg_pat = 7'h24;
      4'h3: w_seg_pat = 7'h30;
      4'h4: w_seg_pat = 7'h19;
      4'h5: w_seg_pat = 7'h12;
      4'h6: w_seg_pat = 7'h02;
      4'h7: w_seg_pat = 7'h78;
      4'h8: w_seg_pat = 7'h00;
      4'h9: w_seg_pat = 7'h10;
      4'hA: w_seg_pat = 7'h08;
      4'hB: w_seg_pat = 7'h03;
      4'hC: w_seg_pat = 7'h46;
      4'hD: w_seg_pat = 7'h21;
      4'hE: w_seg_pat = 7'h06;
      4'hF: w_seg_pat = 7'h0E;
      default: w_seg_pat = 7'h7F;
    endcase
  end

  // Display outputs are registered so they are glitch-free at the pins.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_an  <= 8'hFF;
      r_seg <= 7'h7F;
      r_dp  <= 1'b1;
    end else if (w_ctrl[0]) begin
      r_an  <= ~(8'd1 << r_digit);
      r_seg <= w_seg_pat;
      r_dp  <= ~w_dpmask[r_digit];
    end else begin
      r_an  <= 8'hFF;
      r_seg <= 7'h7F;
      r_dp  <= 1'b1;
    end
  end

  assign AN  = r_an;
  assign SEG = r_seg;
  assign DP  = r_dp;

endmodule

// File: tb/tb_sevenseg_axil_slave.sv
// tb_sevenseg_axil_slave: self-checking bench for the AXI4-Lite seven-segment slave.
// Latency: n/a (bench).
// Backpressure: exercises BREADY/RREADY stalls and simultaneous read/write.

module tb_sevenseg_axil_slave;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [3:0]  S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [3:0]  S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic [6:0]  SEG;
  logic        DP;
  logic [7:0]  AN;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the four registers as plain words.
  logic [31:0] model [4];
  logic [6:0]  hex_lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  sevenseg_axil_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .SEG(SEG), .DP(DP), .AN(AN)
  );

  always #5 ACLK = ~ACLK;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
    return r;
  endfunction

  // Full write transaction; reports a timeout instead of hanging.
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output bit tmo, output logic [1:0] resp);
    int n;
    tmo = 1'b0;
    resp = 2'b11;
    @(negedge ACLK);
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
    n = 0;
    while (!(S_AXI_AWREADY && S_AXI_WREADY) && n < 32) begin @(negedge ACLK); n++; end
    if (n >= 32) tmo = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    n = 0;
    while (!S_AXI_BVALID && n < 32) begin @(negedge ACLK); n++; end
    if (n >= 32) tmo = 1'b1;
    resp = S_AXI_BRESP;
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data,
                          output bit tmo, output logic [1:0] resp);
    int n;
    tmo = 1'b0;
    resp = 2'b11;
    data = 'x;
    @(negedge ACLK);
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
    n = 0;
    while (!S_AXI_ARREADY && n < 32) begin @(negedge ACLK); n++; end
    if (n >= 32) tmo = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 1'b0;
    n = 0;
    while (!S_AXI_RVALID && n < 32) begin @(negedge ACLK); n++; end
    if (n >= 32) tmo = 1'b1;
    data = S_AXI_RDATA;
    resp = S_AXI_RRESP;
    @(posedge ACLK); #1;
    S_AXI_RREADY = 1'b0;
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
    repeat (3) @(negedge ACLK);
    n_checks++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_handshake: aw/w/b/ar/r = %b, want 00000",
               {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID});
    end
    n_checks++;
    if (S_AXI_RDATA !== 32'h0) begin
      n_errors++; $display("FAIL reset_rdata: got %h, want 0", S_AXI_RDATA);
    end
    n_checks++;
    if ({AN, SEG, DP} !== {8'hFF, 7'h7F, 1'b1}) begin
      n_errors++; $display("FAIL reset_display: AN=%h SEG=%h DP=%b, want FF 7F 1", AN, SEG, DP);
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    @(negedge ACLK);
    ARESET = 1'b0;
    for (int r = 0; r < 4; r++) model[r] = '0;
  endtask

  task automatic test_basic_rw();
    bit tmo; logic [1:0] resp; logic [31:0] d;
    for (int r = 0; r < 4; r++) begin
      axi_write(4'(r * 4), 32'(r + 1), 4'hF, tmo, resp);
      model[r] = 32'(r + 1);
      n_checks++;
      if (tmo || resp !== 2'b00) begin
        n_errors++; $display("FAIL basic_write[%0d]: timeout=%0d bresp=%b, want 0 00", r, tmo, resp);
      end
    end
    for (int r = 0; r < 4; r++) begin
      axi_read(4'(r * 4), d, tmo, resp);
      n_checks++;
      if (tmo || resp !== 2'b00 || d !== 32'(r + 1)) begin
        n_errors++;
        $display("FAIL basic_read[%0d]: timeout=%0d rresp=%b data=%h, want 0 00 %h", r, tmo, resp, d, r + 1);
      end
    end
  endtask

  task automatic test_wstrb();
    bit tmo; logic [1:0] resp; logic [31:0] d;
    axi_write(4'h4, 32'hFFFF_FFFF, 4'hF, tmo, resp);
    axi_write(4'h4, 32'h0000_0012, 4'b0001, tmo, resp);
    model[1] = 32'hFFFF_FF12;
    axi_read(4'h4, d, tmo, resp);
    n_checks++;
    if (tmo || d !== 32'hFFFF_FF12) begin
      n_errors++; $display("FAIL wstrb_byte0: timeout=%0d data=%h, want FFFFFF12", tmo, d);
    end
  endtask

  task automatic test_random_rw();
    bit tmo; logic [1:0] resp; logic [31:0] d, wd;
    logic [3:0] addr, strb;
    int idx;
    for (int i = 0; i < 60; i++) begin
      // low address bits are random to show they are ignored
      addr = 4'($urandom_range(0, 15));
      idx  = int'(addr[3:2]);
      if ($urandom_range(0, 1) == 1) begin
        wd = $urandom; strb = 4'($urandom_range(0, 15));
        axi_write(addr, wd, strb, tmo, resp);
        model[idx] = merge(model[idx], wd, strb);
        n_checks++;
        if (tmo || resp !== 2'b00) begin
          n_errors++; $display("FAIL rand_write[%0d]: timeout=%0d bresp=%b, want 0 00", i, tmo, resp);
        end
      end else begin
        axi_read(addr, d, tmo, resp);
        n_checks++;
        if (tmo || resp !== 2'b00 || d !== model[idx]) begin
          n_errors++;
          $display("FAIL rand_read[%0d] addr=%h: timeout=%0d rresp=%b data=%h, want 0 00 %h",
                   i, addr, tmo, resp, d, model[idx]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit tmo; logic [1:0] resp; logic [31:0] d, d1, d2;
    int n;
    bit stall_bad;
    d1 = $urandom; d2 = $urandom;
    @(negedge ACLK);
    S_AXI_AWADDR = 4'h4; S_AXI_WDATA = d1; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
    n = 0;
    while (!S_AXI_AWREADY && n < 32) begin @(negedge ACLK); n++; end
    @(posedge ACLK); #1;
    // second write presented immediately while the first response is stalled
    S_AXI_AWADDR = 4'h8; S_AXI_WDATA = d2;
    stall_bad = 1'b0;
    repeat (5) begin
      @(negedge ACLK);
      if (!S_AXI_BVALID || S_AXI_AWREADY || S_AXI_WREADY) stall_bad = 1'b1;
    end
    n_checks++;
    if (n >= 32 || stall_bad) begin
      n_errors++;
      $display("FAIL bstall_hold: timeout=%0d stall_violation=%0d (BVALID=%b AWREADY=%b), want 0 0",
               n >= 32, stall_bad, S_AXI_BVALID, S_AXI_AWREADY);
    end
    S_AXI_BREADY = 1'b1;
    n = 0;
    while (!S_AXI_AWREADY && n < 32) begin @(negedge ACLK); n++; end
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    n_checks++;
    if (n >= 32 || !S_AXI_BVALID) begin
      n_errors++; $display("FAIL bstall_second: timeout=%0d BVALID=%b, want 0 1", n >= 32, S_AXI_BVALID);
    end
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0;
    model[1] = d1; model[2] = d2;
    axi_read(4'h4, d, tmo, resp);
    n_checks++;
    if (tmo || d !== d1) begin
      n_errors++; $display("FAIL bstall_rd_first: data=%h, want %h", d, d1);
    end
    axi_read(4'h8, d, tmo, resp);
    n_checks++;
    if (tmo || d !== d2) begin
      n_errors++; $display("FAIL bstall_rd_second: data=%h, want %h", d, d2);
    end
  endtask

  task automatic test_simul_rw();
    logic [31:0] oldv, newv;
    int n;
    bit unstable;
    oldv = model[2]; newv = ~oldv ^ $urandom;
    @(negedge ACLK);
    S_AXI_AWADDR = 4'h8; S_AXI_WDATA = newv; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = 4'h8; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
    n = 0;
    while (!(S_AXI_AWREADY && S_AXI_ARREADY) && n < 32) begin @(negedge ACLK); n++; end
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    n_checks++;
    if (n >= 32 || !S_AXI_RVALID || !S_AXI_BVALID || S_AXI_RDATA !== oldv) begin
      n_errors++;
      $display("FAIL simul_rw_old: timeout=%0d RVALID=%b BVALID=%b RDATA=%h, want 0 1 1 %h",
               n >= 32, S_AXI_RVALID, S_AXI_BVALID, S_AXI_RDATA, oldv);
    end
    unstable = 1'b0;
    repeat (3) begin
      @(negedge ACLK);
      if (!S_AXI_RVALID || S_AXI_RDATA !== oldv) unstable = 1'b1;
    end
    n_checks++;
    if (unstable) begin
      n_errors++; $display("FAIL rvalid_hold: RVALID=%b RDATA=%h, want 1 %h", S_AXI_RVALID, S_AXI_RDATA, oldv);
    end
    S_AXI_RREADY = 1'b1; S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_RREADY = 1'b0; S_AXI_BREADY = 1'b0;
    n_checks++;
    if (S_AXI_RVALID || S_AXI_BVALID) begin
      n_errors++; $display("FAIL simul_rw_drain: RVALID=%b BVALID=%b, want 0 0", S_AXI_RVALID, S_AXI_BVALID);
    end
    model[2] = newv;
  endtask

  task automatic test_display_scan(input logic [31:0] value, input logic [31:0] dpmask,
                                   input logic [31:0] div);
    bit tmo, bad; logic [1:0] resp;
    logic [7:0] prev_an, exp_an;
    int period, cyc, idx;
    bad = 1'b0;
    axi_write(4'h0, {$urandom_range(0, 65535), 15'h0, 1'b1}, 4'hF, tmo, resp); bad |= tmo;
    axi_write(4'h4, value, 4'hF, tmo, resp);  bad |= tmo;
    axi_write(4'h8, dpmask, 4'hF, tmo, resp); bad |= tmo;
    axi_write(4'hC, div, 4'hF, tmo, resp);    bad |= tmo;
    model[1] = value; model[2] = dpmask; model[3] = div;
    period = int'(div[15:0]) + 1;
    // sync to the first digit change
    @(negedge ACLK);
    prev_an = AN; cyc = 0;
    while (AN === prev_an && cyc < 2 * period + 8) begin @(negedge ACLK); cyc++; end
    idx = -1;
    for (int b = 0; b < 8; b++) if (AN[b] === 1'b0) idx = b;
    exp_an = (idx < 0) ? 8'hxx : ~(8'd1 << idx);
    n_checks++;
    if (bad || idx < 0 || AN !== exp_an) begin
      n_errors++; $display("FAIL scan_sync div=%0d: cfg_timeout=%0d AN=%h, want one-hot-low digit", div[15:0], bad, AN);
      return;
    end
    for (int t = 0; t < 10; t++) begin
      prev_an = AN; cyc = 0;
      do begin @(negedge ACLK); cyc++; end while (AN === prev_an && cyc < period + 4);
      idx = (idx + 1) % 8;
      exp_an = ~(8'd1 << idx);
      n_checks++;
      if (cyc != period || AN !== exp_an || SEG !== hex_lut[value[4*idx +: 4]] || DP !== ~dpmask[idx]) begin
        n_errors++;
        $display("FAIL scan_step div=%0d t=%0d: cycles=%0d AN=%h SEG=%h DP=%b, want %0d %h %h %b",
                 div[15:0], t, cyc, AN, SEG, DP, period, exp_an, hex_lut[value[4*idx +: 4]], ~dpmask[idx]);
      end
    end
  endtask

  task automatic test_display_off();
    bit tmo; logic [1:0] resp;
    int bad_cnt;
    axi_write(4'h0, {$urandom_range(0, 65535), 15'h0, 1'b0}, 4'hF, tmo, resp);
    axi_write(4'h4, $urandom, 4'hF, tmo, resp);
    axi_write(4'hC, 32'h0, 4'hF, tmo, resp);
    bad_cnt = 0;
    repeat (12) begin
      @(negedge ACLK);
      if (AN !== 8'hFF || SEG !== 7'h7F || DP !== 1'b1) bad_cnt++;
    end
    n_checks++;
    if (tmo || bad_cnt != 0) begin
      n_errors++; $display("FAIL display_off: bad_samples=%0d AN=%h SEG=%h DP=%b, want 0 FF 7F 1", bad_cnt, AN, SEG, DP);
    end
  endtask

  task automatic test_reset_mid();
    bit tmo, stray; logic [1:0] resp; logic [31:0] d;
    int n;
    @(negedge ACLK);
    S_AXI_AWADDR = 4'h0; S_AXI_WDATA = 32'h1; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = 4'h4; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
    n = 0;
    while (!(S_AXI_AWREADY && S_AXI_ARREADY) && n < 32) begin @(negedge ACLK); n++; end
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    repeat (3) @(posedge ACLK);
    #2;
    n_checks++;
    if (n >= 32 || !S_AXI_BVALID || !S_AXI_RVALID) begin
      n_errors++; $display("FAIL rstmid_pre: BVALID=%b RVALID=%b, want 1 1", S_AXI_BVALID, S_AXI_RVALID);
    end
    ARESET = 1'b1;
    #1;
    n_checks++;
    if (S_AXI_BVALID || S_AXI_RVALID || S_AXI_RDATA !== 32'h0 || AN !== 8'hFF || SEG !== 7'h7F || DP !== 1'b1) begin
      n_errors++;
      $display("FAIL rstmid_async: BVALID=%b RVALID=%b RDATA=%h AN=%h SEG=%h DP=%b, want 0 0 0 FF 7F 1",
               S_AXI_BVALID, S_AXI_RVALID, S_AXI_RDATA, AN, SEG, DP);
    end
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    stray = 1'b0;
    repeat (6) begin
      @(negedge ACLK);
      if (S_AXI_BVALID || S_AXI_RVALID) stray = 1'b1;
    end
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
    n_checks++;
    if (stray) begin
      n_errors++; $display("FAIL rstmid_stray_resp: response seen after reset release, want none");
    end
    for (int r = 0; r < 4; r++) model[r] = '0;
    for (int r = 0; r < 4; r++) begin
      axi_read(4'(r * 4), d, tmo, resp);
      n_checks++;
      if (tmo || d !== model[r]) begin
        n_errors++; $display("FAIL rstmid_reg[%0d]: timeout=%0d data=%h, want %h", r, tmo, d, model[r]);
      end
    end
  endtask

  initial begin
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    ARESET = 1'b1;

    test_reset();
    test_basic_rw();
    test_wstrb();
    test_random_rw();
    test_back_to_back();
    test_simul_rw();
    test_display_scan(32'h7654_3210, 32'h0000_0001, 32'd3);
    test_display_scan(32'h0000_0000, 32'h0000_0080, 32'd0);
    for (int k = 0; k < 3; k++) begin
      test_display_scan($urandom, $urandom, {16'($urandom), 16'($urandom_range(1, 5))});
    end
    test_display_off();
    test_reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
